spi_read_ctrl: RTL

//  Sequencer for the SPI read datapath: on a start request, runs one
//  SPI mode-0 read frame from a serial ADC and shifts MISO in MSB first.
//  At frame end it issues a one-cycle load-enable so the downstream

---
 rtl/spi_read_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_read_ctrl.sv
// spi_read_ctrl: SPI mode-0 read-frame sequencer for a serial ADC.
// Runs one frame per request: CS setup, LeadBits+Width SCLK bits sampled
// MSB first, CS hold, then a one-cycle load enable (hab_o) for the
// downstream capture register, with the captured sample on data_o.
// Optional feature macro: SPI_READ_CONT_EN adds cont_i, which restarts
// frames automatically a fixed gap after each DONE while it stays high.
module spi_read_ctrl #(
    parameter int unsigned Width    = 12,
    parameter int unsigned ClkDiv   = 2,
    parameter int unsigned LeadBits = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
`ifdef SPI_READ_CONT_EN
    input  logic             cont_i,
`endif
    input  logic             miso_i,
    output logic             sclk_o,
    output logic             cs_no,
    output logic             busy_o,
    output logic             hab_o,
    output logic [Width-1:0] data_o
);

    localparam int unsigned NumBits = LeadBits + Width;
    localparam int unsigned BitW    = $clog2(NumBits + 1);
    localparam int unsigned DivW    = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(NumBits - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [DivW-1:0]  r_div;
    logic [DivW-1:0]  w_div_next;
    logic [BitW-1:0]  r_bit;
    logic [BitW-1:0]  w_bit_next;
    logic             r_sclk;
    logic             w_sclk_next;
    logic             r_cs_n;
    logic             w_cs_n_next;
    logic             r_busy;
    logic             w_busy_next;
    logic             r_hab;
    logic             w_hab_next;
    logic [Width-1:0] r_shift;
    logic [Width-1:0] w_shift_next;
    logic [Width-1:0] w_shift_in;
    logic             w_go;

    // Older bits move up; lead bits fall out of the top once Width bits follow.
    assign w_shift_in = (r_shift << 1) | Width'(miso_i);

`ifdef SPI_READ_CONT_EN
    // Idle-cycle counter: the restart fires so that CS falls 4*ClkDiv cycles
    // after DONE (DONE -> IDLE takes one cycle, acceptance takes another).
    localparam int unsigned GapW    = $clog2(4 * ClkDiv);
    localparam logic [GapW-1:0] GapLast = GapW'(4 * ClkDiv - 2);

    logic [GapW-1:0] r_gap;
    logic [GapW-1:0] w_gap_next;

    assign w_go = start_i | (cont_i & (r_gap == GapLast));

    // Count idle cycles since the last DONE, saturating at the restart point.
    always_comb begin
        w_gap_next = r_gap;
        if (r_state == StDone) begin
            w_gap_next = '0;
        end else if (r_state == StIdle && r_gap != GapLast) begin
            w_gap_next = r_gap + GapW'(1);
        end
    end

    // Gap counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gap <= '0;
        end else begin
            r_gap <= w_gap_next;
        end
    end
`else
    assign w_go = start_i;
`endif

    // Next-state and next-output decode; all outputs are registered.
    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_bit_next   = r_bit;
        w_sclk_next  = r_sclk;
        w_cs_n_next  = r_cs_n;
        w_busy_next  = r_busy;
        w_hab_next   = 1'b0;
        w_shift_next = r_shift;

        unique case (r_state)
            StIdle: begin
                w_sclk_next = 1'b0;
                w_cs_n_next = 1'b1;
                w_busy_next = 1'b0;
                if (w_go) begin
                    w_state_next = StSetup;
                    w_cs_n_next  = 1'b0;
                    w_busy_next  = 1'b1;
                    w_div_next   = '0;
                    w_bit_next   = '0;
                    w_shift_next = '0;
                end
            end
            StSetup: begin
                if (r_div == DivLast) begin
                    w_state_next = StShift;
                    w_div_next   = '0;
                end else begin
                    w_div_next = r_div + DivW'(1);
                end
            end
            StShift: begin
                if (r_div == DivLast) begin
                    w_div_next = '0;
                    if (!r_sclk) begin
                        // Rising SCLK edge: sample MISO on this same clk_i edge.
                        w_sclk_next  = 1'b1;
                        w_shift_next = w_shift_in;
                    end else begin
                        w_sclk_next = 1'b0;
                        if (r_bit == BitLast) begin
                            w_state_next = StHold;
                            w_bit_next   = '0;
                        end else begin
                            w_bit_next = r_bit + BitW'(1);
                        end
                    end
                end else begin
                    w_div_next = r_div + DivW'(1);
                end
            end
            StHold: begin
                if (r_div == DivLast) begin
                    w_state_next = StDone;
                    w_div_next   = '0;
                    w_cs_n_next  = 1'b1;
                    w_hab_next   = 1'b1;
                end else begin
                    w_div_next = r_div + DivW'(1);
                end
            end
            StDone: begin
                w_state_next = StIdle;
                w_busy_next  = 1'b0;
            end
            default: begin
                w_state_next = StIdle;
                w_sclk_next  = 1'b0;
                w_cs_n_next  = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_div   <= '0;
            r_bit   <= '0;
            r_sclk  <= 1'b0;
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_hab   <= 1'b0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_bit   <= w_bit_next;
            r_sclk  <= w_sclk_next;
            r_cs_n  <= w_cs_n_next;
            r_busy  <= w_busy_next;
            r_hab   <= w_hab_next;
            r_shift <= w_shift_next;
        end
    end

    assign sclk_o = r_sclk;
    assign cs_no  = r_cs_n;
    assign busy_o = r_busy;
    assign hab_o  = r_hab;
    assign data_o = r_shift;

endmodule
